multiplier_stream: RTL and testbench
====================================

# multiplier_stream

Parametrised streaming multiplier. It pairs an operand FIFO of configurable depth with an iterative radix-4 modified-Booth datapath of configurable width, and selects signed or unsigned arithmetic per entry. Results leave through a valid/ready handshake, so the downstream consumer can apply back-pressure. It replaces the fixed 8×8, poll-and-start wrapper as the multiply engine in front of downstream processing.

## Interface
- WIDTH, 8: operand width in bits; must be even and ≥ 4. Product is 2·WIDTH bits.
- DEPTH, 4: operand FIFO depth in entries; must be a power of two and ≥ 2.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- Write_Req  in  1  push {Write_Signed, FIFO_Write_Data} on this edge.
- FIFO_Write_Data  in  2·WIDTH  [2W-1:W] = A, [W-1:0] = B.
- Write_Signed  in  1  1 = two's-complement operands, 0 = unsigned; stored with the entry.
- Left_Sig  out  clog2(DEPTH)+1  free FIFO slots (DEPTH − count).
- Full  out  1  count == DEPTH.
- Drop_Sig  out  1  one-cycle pulse on the edge after a rejected write.
- Busy  out  1  controller not in IDLE.
- Product  out  2·WIDTH  result; stable while Product_Valid = 1.
- Product_Valid  out  1  result available.
- Product_Ready  in  1  consumer accepts; transfer occurs on an edge with Valid & Ready.

## Operation
- FIFO: circular buffer with DEPTH × (2W+1) storage, read/write pointers wrapping modulo DEPTH, and a registered count. Head data is show-ahead, so a pop and an operand capture happen on the same edge.
- A write while Full is dropped, even if a pop occurs on the same edge. Storage and count are unchanged and Drop_Sig pulses.
- A write and a pop on the same edge: both take effect and count is unchanged.
- Controller states:
  - IDLE: if count ≠ 0, pop and load, then go to MUL.
  - MUL: run one Booth step per cycle for STEPS = W/2+1 cycles, then register Product, set Product_Valid, and go to DONE.
  - DONE: hold Product and Valid. On an edge with Product_Ready:
    - if count ≠ 0, pop and load, clear Valid, and go to MUL (back-to-back);
    - otherwise clear Valid and go to IDLE.
- Load:
  - the multiplicand is extended to 2W+2 bits, and the multiplier to W+2 bits with an appended 0 LSB;
  - extension is sign extension when Write_Signed = 1 and zero extension otherwise;
  - the accumulator is cleared and the step counter reset.
- Booth step:
  - recode 3 multiplier bits to a digit in {−2,−1,0,+1,+2};
  - add digit·M·4^k to the accumulator, computed modulo 2^(2W+2);
  - shift the multiplier window by 2.
- Product = accumulator[2W-1:0], the exact product. A signed result is two's complement; an unsigned result fits without overflow.
- Entries are processed strictly in FIFO order, and each entry uses the mode it was written with.

## Timing
- Reset values (applied immediately on RST rise): Product 0, Product_Valid 0, Busy 0, Drop_Sig 0, Full 0, Left_Sig DEPTH. FIFO pointers and count are 0 and the controller is in IDLE.
- Reset mid-operation abandons the multiply and flushes the FIFO; no partial result is ever presented.
- Latency from an idle start: write sampled on edge 0; pop and load on edge 1; steps on edges 2 … W/2+2; Product_Valid high after edge W/2+2. For W = 8 that is 6 edges.
- Back-to-back: a handshake on edge h with a non-empty FIFO gives Valid low after h and high again after edge h+W/2+1. Throughput is one result per W/2+2 cycles.
- Left_Sig and Full update on the edge after the push or pop.
- Product and Product_Valid change only on a handshake edge, on a transition into DONE, or on reset.

## Test plan
- W=8, unsigned: write 0xFFFF on edge 0 with Ready = 1 → Product_Valid rises after edge 6 with Product = 0xFE01; Busy is 1 from edge 1 to 6; Left_Sig returns to 4.
- W=8, mode mix:
  - signed 0x8080 → 0x4000;
  - signed 0xFF02 → 0xFFFE;
  - unsigned 0xFF02 → 0x01FE;
  - all three delivered in order.
- Full and drop (W=8, DEPTH=4): hold Ready = 0 and write 6 entries on consecutive edges 0–5.
  - Entry 1 is popped on edge 1.
  - Full = 1 and Left_Sig = 0 after edge 4.
  - The 6th write is dropped and Drop_Sig pulses after edge 5.
  - Releasing Ready drains exactly 5 correct products in order.
- Back-pressure: hold Ready = 0 for 20 cycles after Valid rises → Product is stable throughout. Raise Ready with 2 entries queued → the next Valid rises 5 edges after the handshake edge.
- Reset mid-MUL: assert RST asynchronously during step 2 with 2 entries queued → all outputs take their reset values without waiting for a clock edge. After release, Left_Sig = 4, Product_Valid stays 0, and no stale product appears.
- WIDTH=16: signed A = 0x7FFF, B = 0x8000 → Product = 0xC0008000 after edge 10 from the write; unsigned 0xFFFF × 0xFFFF → 0xFFFE0001.

Source files
------------

// File: rtl/multiplier_stream.sv
// Streaming multiplier: operand FIFO feeding an iterative radix-4 Booth datapath,
// signed/unsigned per entry, results delivered over a valid/ready handshake.
module multiplier_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       Write_Req,
  input  logic [2*WIDTH-1:0]         FIFO_Write_Data,
  input  logic                       Write_Signed,
  output logic [$clog2(DEPTH):0]     Left_Sig,
  output logic                       Full,
  output logic                       Drop_Sig,
  output logic                       Busy,
  output logic [2*WIDTH-1:0]         Product,
  output logic                       Product_Valid,
  input  logic                       Product_Ready
);

  localparam int AW    = $clog2(DEPTH);
  localparam int STEPS = WIDTH / 2 + 1;
  localparam int SW    = $clog2(STEPS);
  localparam int PW    = 2 * WIDTH + 2;
  localparam int MW    = WIDTH + 3;
  localparam int EW    = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [EW-1:0]     r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic              r_drop;

  logic [PW-1:0]     r_mcand;
  logic [MW-1:0]     r_mplier;
  logic [PW-1:0]     r_acc;
  logic [SW-1:0]     r_step;
  logic [2*WIDTH-1:0] r_product;
  logic              r_valid;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_step;
  logic              w_last;
  logic [EW-1:0]     w_head;
  logic              w_sgn;
  logic [WIDTH-1:0]  w_a;
  logic [WIDTH-1:0]  w_b;
  logic [PW-1:0]     w_a_ext;
  logic [MW-1:0]     w_b_ext;
  logic [PW-1:0]     w_m2;
  logic [PW-1:0]     w_addend;
  logic [PW-1:0]     w_acc_next;

  // ---------------- operand FIFO ----------------
  assign w_full  = (r_count == (AW + 1)'(DEPTH));
  assign w_empty = (r_count == '0);
  // A write while full is dropped even if a pop frees a slot on the same edge.
  assign w_push  = Write_Req && !w_full;
  assign w_head  = r_mem[r_rptr];

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= {Write_Signed, FIFO_Write_Data};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= Write_Req && w_full;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- controller ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_MUL;
        end
      end
      S_MUL: begin
        w_step = 1'b1;
        if (r_step == SW'(STEPS - 1)) begin
          w_last       = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (Product_Ready) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = S_MUL;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------- Booth datapath ----------------
  assign w_sgn   = w_head[2*WIDTH];
  assign w_a     = w_head[2*WIDTH-1:WIDTH];
  assign w_b     = w_head[WIDTH-1:0];
  assign w_a_ext = {{(WIDTH + 2){w_sgn & w_a[WIDTH-1]}}, w_a};
  assign w_b_ext = {{2{w_sgn & w_b[WIDTH-1]}}, w_b, 1'b0};
  assign w_m2    = {r_mcand[PW-2:0], 1'b0};

  always_comb begin
    w_addend = '0;
    case (r_mplier[2:0])
      3'b001, 3'b010: w_addend = r_mcand;
      3'b011:         w_addend = w_m2;
      3'b100:         w_addend = -w_m2;
      3'b101, 3'b110: w_addend = -r_mcand;
      default:        w_addend = '0;
    endcase
  end

  assign w_acc_next = r_acc + w_addend;

  // The multiplicand is pre-shifted by 4 each step instead of scaling the addend.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_step    <= '0;
      r_product <= '0;
      r_valid   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_mcand  <= w_a_ext;
        r_mplier <= w_b_ext;
        r_acc    <= '0;
        r_step   <= '0;
      end else if (w_step) begin
        r_mcand  <= {r_mcand[PW-3:0], 2'b00};
        r_mplier <= {2'b00, r_mplier[MW-1:2]};
        r_acc    <= w_acc_next;
        r_step   <= r_step + SW'(1);
      end
      if (w_last) begin
        r_product <= w_acc_next[2*WIDTH-1:0];
        r_valid   <= 1'b1;
      end else if (r_state == S_DONE && Product_Ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign Left_Sig      = (AW + 1)'(DEPTH) - r_count;
  assign Full          = w_full;
  assign Drop_Sig      = r_drop;
  assign Busy          = (r_state != S_IDLE);
  assign Product       = r_product;
  assign Product_Valid = r_valid;

endmodule

// File: tb/tb_multiplier_stream.sv
// Directed bench for multiplier_stream: vector table plus multi-cycle sequences
// on an 8-bit and a 16-bit instance.
module tb_multiplier_stream;

  logic        CLK = 1'b0;
  logic        RST;

  logic        wr, wsgn, pr;
  logic [15:0] wdata;
  logic [2:0]  left;
  logic        full, drop, busy, pv;
  logic [15:0] prod;

  logic        wr16, wsgn16, pr16;
  logic [31:0] wdata16;
  logic [2:0]  left16;
  logic        full16, drop16, busy16, pv16;
  logic [31:0] prod16;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [10];

  always #5 CLK = ~CLK;

  multiplier_stream #(.WIDTH(8), .DEPTH(4)) u8 (
    .CLK(CLK), .RST(RST), .Write_Req(wr), .FIFO_Write_Data(wdata),
    .Write_Signed(wsgn), .Left_Sig(left), .Full(full), .Drop_Sig(drop),
    .Busy(busy), .Product(prod), .Product_Valid(pv), .Product_Ready(pr)
  );

  multiplier_stream #(.WIDTH(16), .DEPTH(4)) u16 (
    .CLK(CLK), .RST(RST), .Write_Req(wr16), .FIFO_Write_Data(wdata16),
    .Write_Signed(wsgn16), .Left_Sig(left16), .Full(full16), .Drop_Sig(drop16),
    .Busy(busy16), .Product(prod16), .Product_Valid(pv16), .Product_Ready(pr16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push8(input logic s, input logic [7:0] a, input logic [7:0] b);
    wr    = 1'b1;
    wsgn  = s;
    wdata = {a, b};
    tick();
    wr    = 1'b0;
  endtask

  task automatic wait_valid8(input int budget, input string name);
    int k = 0;
    while (!pv && k < budget) begin
      tick();
      k++;
    end
    chk({name, " valid"}, {31'b0, pv}, 32'd1);
  endtask

  task automatic collect8(input logic [15:0] exp, input string name);
    wait_valid8(30, name);
    chk(name, {16'b0, prod}, {16'b0, exp});
    pr = 1'b1;
    tick();
    pr = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[1] = '{1'b1, 8'hFF, 8'h02, 16'hFFFE};
    vecs[2] = '{1'b0, 8'hFF, 8'h02, 16'h01FE};
    vecs[3] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
    vecs[4] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    vecs[5] = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vecs[6] = '{1'b0, 8'h12, 8'h34, 16'h03A8};
    vecs[7] = '{1'b1, 8'h00, 8'h9C, 16'h0000};
    vecs[8] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
    vecs[9] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};

    RST = 1'b1;
    wr = 1'b0; wsgn = 1'b0; wdata = '0; pr = 1'b0;
    wr16 = 1'b0; wsgn16 = 1'b0; wdata16 = '0; pr16 = 1'b0;
    #1;
    chk("rst product", {16'b0, prod}, 32'h0);
    chk("rst valid", {31'b0, pv}, 32'h0);
    chk("rst busy", {31'b0, busy}, 32'h0);
    chk("rst drop", {31'b0, drop}, 32'h0);
    chk("rst full", {31'b0, full}, 32'h0);
    chk("rst left", {29'b0, left}, 32'd4);
    chk("rst left16", {29'b0, left16}, 32'd4);
    tick();
    tick();
    RST = 1'b0;
    tick();

    // Idle-start latency, unsigned 0xFF x 0xFF with Ready held high.
    pr = 1'b1;
    push8(1'b0, 8'hFF, 8'hFF);
    chk("lat left e0", {29'b0, left}, 32'd3);
    chk("lat busy e0", {31'b0, busy}, 32'd0);
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk($sformatf("lat busy e%0d", e), {31'b0, busy}, 32'd1);
      chk($sformatf("lat valid e%0d", e), {31'b0, pv}, (e == 6) ? 32'd1 : 32'd0);
      if (e == 1) chk("lat left e1", {29'b0, left}, 32'd4);
    end
    chk("lat product", {16'b0, prod}, 32'h0000FE01);
    tick();
    chk("lat valid after hs", {31'b0, pv}, 32'd0);
    chk("lat busy after hs", {31'b0, busy}, 32'd0);
    pr = 1'b0;

    for (int i = 0; i < 10; i++) begin
      push8(vecs[i].sgn, vecs[i].a, vecs[i].b);
      collect8(vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Mode mix queued together, delivered in order.
    for (int i = 0; i < 3; i++) push8(vecs[i].sgn, vecs[i].a, vecs[i].b);
    for (int i = 0; i < 3; i++) collect8(vecs[i].exp, $sformatf("mix%0d", i));

    // Full and drop with Ready low.
    wr = 1'b1;
    wsgn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wdata = {8'(i + 1), 8'(i + 3)};
      tick();
      case (i)
        0: chk("fd left e0", {29'b0, left}, 32'd3);
        1: chk("fd left e1", {29'b0, left}, 32'd3);
        2: chk("fd left e2", {29'b0, left}, 32'd2);
        3: begin
          chk("fd left e3", {29'b0, left}, 32'd1);
          chk("fd full e3", {31'b0, full}, 32'd0);
        end
        4: begin
          chk("fd full e4", {31'b0, full}, 32'd1);
          chk("fd left e4", {29'b0, left}, 32'd0);
          chk("fd drop e4", {31'b0, drop}, 32'd0);
        end
        default: begin
          chk("fd drop e5", {31'b0, drop}, 32'd1);
          chk("fd full e5", {31'b0, full}, 32'd1);
        end
      endcase
    end
    wr = 1'b0;
    tick();
    chk("fd drop e6", {31'b0, drop}, 32'd0);
    for (int i = 0; i < 5; i++) collect8(16'((i + 1) * (i + 3)), $sformatf("fd drain%0d", i));
    for (int k = 0; k < 15; k++) tick();
    chk("fd no sixth", {31'b0, pv}, 32'd0);
    chk("fd left end", {29'b0, left}, 32'd4);

    // Back-pressure: stable product, then back-to-back latency.
    push8(1'b0, 8'h12, 8'h34);
    wait_valid8(20, "bp first");
    push8(1'b1, 8'h80, 8'h7F);
    push8(1'b0, 8'h0F, 8'h0F);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("bp hold product", {16'b0, prod}, 32'h03A8);
      chk("bp hold valid", {31'b0, pv}, 32'd1);
    end
    pr = 1'b1;
    tick();
    pr = 1'b0;
    chk("bp valid h", {31'b0, pv}, 32'd0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("bp valid h+%0d", e), {31'b0, pv}, (e == 5) ? 32'd1 : 32'd0);
    end
    collect8(16'hC080, "bp second");
    collect8(16'h00E1, "bp third");

    // Asynchronous reset during the second Booth step.
    push8(1'b0, 8'h11, 8'h22);
    push8(1'b0, 8'h33, 8'h44);
    push8(1'b0, 8'h55, 8'h66);
    chk("mr busy before", {31'b0, busy}, 32'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("mr product", {16'b0, prod}, 32'h0);
    chk("mr valid", {31'b0, pv}, 32'd0);
    chk("mr busy", {31'b0, busy}, 32'd0);
    chk("mr left", {29'b0, left}, 32'd4);
    chk("mr full", {31'b0, full}, 32'd0);
    chk("mr drop", {31'b0, drop}, 32'd0);
    #3;
    RST = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("mr no stale valid", {31'b0, pv}, 32'd0);
    end
    chk("mr left after", {29'b0, left}, 32'd4);
    chk("mr busy after", {31'b0, busy}, 32'd0);

    // 16-bit instance.
    wr16 = 1'b1;
    wsgn16 = 1'b1;
    wdata16 = {16'h7FFF, 16'h8000};
    tick();
    wr16 = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e >= 9) chk($sformatf("w16 valid e%0d", e), {31'b0, pv16}, (e == 10) ? 32'd1 : 32'd0);
    end
    chk("w16 signed", prod16, 32'hC0008000);
    pr16 = 1'b1;
    tick();
    pr16 = 1'b0;
    wr16 = 1'b1;
    wsgn16 = 1'b0;
    wdata16 = {16'hFFFF, 16'hFFFF};
    tick();
    wr16 = 1'b0;
    for (int k = 0; k < 30 && !pv16; k++) tick();
    chk("w16 unsigned valid", {31'b0, pv16}, 32'd1);
    chk("w16 unsigned", prod16, 32'hFFFE0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
